// File: rtl/parity_frame_rx_pkg.sv
// parity_frame_rx_pkg: FSM encoding, line idle level and parity-mode constants for the frame receiver
package parity_frame_rx_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;
    localparam logic LINE_IDLE = 1'b1;
    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD = 1'b1;
endpackage

// File: rtl/parity_frame_rx_if.sv
// parity_frame_rx_if: serial line in, word/status out; err_count exists only with PARITY_FRAME_RX_ERRCNT_EN
interface parity_frame_rx_if #(parameter int DATA_W = 8);
    logic din;
    logic din_valid;
    logic [DATA_W-1:0] data_out;
    logic data_valid;
    logic parity_err;
    logic frame_err;
    logic busy;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    logic [7:0] err_count;
    modport master (output din, din_valid, input data_out, data_valid, parity_err, frame_err, busy, err_count);
    modport slave (input din, din_valid, output data_out, data_valid, parity_err, frame_err, busy, err_count);
`else
    modport master (output din, din_valid, input data_out, data_valid, parity_err, frame_err, busy);
    modport slave (input din, din_valid, output data_out, data_valid, parity_err, frame_err, busy);
`endif
endinterface

// File: rtl/parity_frame_rx_acc.sv
// parity_acc: 1-bit running XOR accumulator with clear and enable
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);
    // clear wins over enable; enable folds d into the running XOR
    always_ff @(posedge clk)
        q <= (rst || clr) ? 1'b0 : en ? q ^ d : q;
endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial start/data/parity/stop receiver with parity and framing checks (optional PARITY_FRAME_RX_ERRCNT_EN adds err_count)
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input logic clk,
    input logic rst,
    parity_frame_rx_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] word;
    logic acc, perr, acc_clr, acc_en;

    parity_acc u_acc (.clk(clk), .rst(rst), .clr(acc_clr), .en(acc_en), .d(bus.din), .q(acc));

    // next state and accumulator control, only advancing on accepted bits
    always_comb begin
        state_n = state;
        acc_clr = 1'b0;
        acc_en = 1'b0;
        if (bus.din_valid) begin
            case (state)
                IDLE: begin
                    acc_clr = bus.din != LINE_IDLE;
                    state_n = bus.din != LINE_IDLE ? DATA : IDLE;
                end
                DATA: begin
                    acc_en = 1'b1;
                    state_n = cnt == LAST ? PARITY : DATA;
                end
                PARITY: state_n = STOP;
                default: state_n = IDLE;
            endcase
        end
    end

    // state register, LSB-first word assembly and frame result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            word <= '0;
            perr <= 1'b0;
            bus.data_out <= '0;
            bus.data_valid <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            state <= state_n;
            bus.data_valid <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    IDLE: cnt <= '0;
                    DATA: begin
                        word <= DATA_W'({bus.din, word} >> 1);
                        cnt <= cnt + 1'b1;
                    end
                    PARITY: perr <= acc ^ bus.din ^ PARITY_ODD;
                    default: begin
                        bus.data_out <= word;
                        bus.parity_err <= perr;
                        bus.frame_err <= ~bus.din;
                        bus.data_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.busy = state != IDLE;

`ifdef PARITY_FRAME_RX_ERRCNT_EN
    // saturating count of completed frames carrying any error
    always_ff @(posedge clk) begin
        if (rst)
            bus.err_count <= '0;
        else if (bus.din_valid && state == STOP && (perr || !bus.din) && bus.err_count != 8'hFF)
            bus.err_count <= bus.err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed and random frames into even- and odd-parity receivers sharing one line
module tb_parity_frame_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b1;
    logic din_valid = 1'b0;
    int checks = 0;
    int failures = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    int exp_pulses = 0;
    int cyc = 0;
    int last_end = 0;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    int ec0 = 0;
    int ec1 = 0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus0.data_valid) pulses0++;
        if (bus1.data_valid) pulses1++;
    end

    parity_frame_rx_if #(.DATA_W(8)) bus0 ();
    parity_frame_rx_if #(.DATA_W(8)) bus1 ();
    assign bus0.din = din;
    assign bus0.din_valid = din_valid;
    assign bus1.din = din;
    assign bus1.din_valid = din_valid;

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            din = 1'($urandom);
            din_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        din = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        ec0 = 0;
        ec1 = 0;
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
        int t0;
        logic pe0, pe1;
        send_bit(1'b0, gap);
        t0 = cyc;
        check("busy_start0", 16'(bus0.busy), 16'd1);
        check("busy_start1", 16'(bus1.busy), 16'd1);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        check("busy_stop", 16'(bus0.busy), 16'd1);
        send_bit(s, gap);
        exp_pulses++;
        pe0 = (($countones(d) + int'(p)) % 2) != 0;
        pe1 = (($countones(d) + int'(p)) % 2) != 1;
        check("frame_len", 16'(cyc - t0), 16'(10 * (gap + 1)));
        check("dv0", 16'(bus0.data_valid), 16'd1);
        check("dv1", 16'(bus1.data_valid), 16'd1);
        check("data0", 16'(bus0.data_out), 16'(d));
        check("data1", 16'(bus1.data_out), 16'(d));
        check("perr_even", 16'(bus0.parity_err), 16'(pe0));
        check("perr_odd", 16'(bus1.parity_err), 16'(pe1));
        check("ferr0", 16'(bus0.frame_err), 16'(!s));
        check("ferr1", 16'(bus1.frame_err), 16'(!s));
        check("busy_done", 16'(bus0.busy), 16'd0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        if ((pe0 || !s) && ec0 < 255) ec0++;
        if ((pe1 || !s) && ec1 < 255) ec1++;
        check("errcnt0", 16'(bus0.err_count), 16'(ec0));
        check("errcnt1", 16'(bus1.err_count), 16'(ec1));
`endif
        last_end = cyc;
    endtask

    initial begin
        int e1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 16'(bus0.data_out), 16'd0);
        check("rst_dv", 16'(bus0.data_valid), 16'd0);
        check("rst_perr", 16'(bus0.parity_err), 16'd0);
        check("rst_ferr", 16'(bus0.frame_err), 16'd0);
        check("rst_busy", 16'(bus0.busy), 16'd0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
        check("rst_errcnt", 16'(bus0.err_count), 16'd0);
`endif
        rst = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        send_frame(8'h81, 1'b0, 1'b1, 1);
        send_bit(1'b1, 0);
        check("idle_stays", 16'(bus0.busy), 16'd0);
        send_bit(1'b0, 0);
        repeat (4) send_bit(1'b1, 0);
        check("abort_busy", 16'(bus0.busy), 16'd1);
        do_reset();
        check("abort_busy_clr", 16'(bus0.busy), 16'd0);
        check("abort_data", 16'(bus0.data_out), 16'd0);
        repeat (3) send_bit(1'b1, 0);
        @(negedge clk);
        #1;
        check("abort_no_pulse", 16'(pulses0), 16'(exp_pulses));
        send_frame(8'h12, 1'b0, 1'b1, 0);
        send_frame(8'h01, 1'b0, 1'b1, 0);
        e1 = last_end;
        send_frame(8'hFE, 1'b0, 1'b1, 0);
        check("b2b_spacing", 16'(last_end - e1), 16'd11);
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 2)) send_bit(1'b1, $urandom_range(0, 1));
            send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2));
        end
        @(negedge clk);
        #1;
        check("pulses0", 16'(pulses0), 16'(exp_pulses));
        check("pulses1", 16'(pulses1), 16'(exp_pulses));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
